jtag_master_seq: RTL
====================

Name: jtag_master_seq

Overview:
- On-chip JTAG master that sequences a 1149.1 TAP from a simple command stream. Commands: TAP reset, IR scan, DR scan, idle clocks.
- Generates TCK/TMS/TDI/TRSTn and captures TDO. Lets SoC-side logic (boot/test controller) drive the debug module TAP the same way the bench JTAG tasks do.
- Sits between a command/response requester and the chip-level JTAG pad mux.

Parameters:
- DATA_W, 64, maximum scan length in bits; width of cmd_data and rsp_data.
- LEN_W, $clog2(DATA_W+1), width of cmd_len.
- CLK_DIV, 4, clk_in cycles per TCK half-period; must be >= 1.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command valid.
- cmd_ready  output  1  command accepted when valid&ready.
- cmd_op  input  2  0=TAP_RESET, 1=SCAN_IR, 2=SCAN_DR, 3=IDLE_CLK.
- cmd_len  input  LEN_W  scan length in bits (SCAN ops) or TCK count (IDLE_CLK).
- cmd_data  input  DATA_W  TDI data, LSB shifted first.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed when valid&ready.
- rsp_data  output  DATA_W  captured TDO bits; bit i = i-th captured bit; bits >= len are zero.
- rsp_err  output  1  command rejected (illegal length).
- busy  output  1  high from command accept until response handshake.
- jtag_tck  output  1  TCK.
- jtag_tms  output  1  TMS.
- jtag_tdi  output  1  TDI.
- jtag_trstn  output  1  TAP reset, active low.
- jtag_tdo  input  1  TDO from the TAP.

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, jtag_tck=0, jtag_tms=1, jtag_tdi=0, jtag_trstn=1. FSM goes to IDLE and the divider counter clears. Reset mid-scan aborts immediately, with no further TCK edges.
- FSM: IDLE -> PRE -> SHIFT -> POST -> RSP -> IDLE.
  - cmd_ready=1 only in IDLE.
  - Accepting a command latches op/len/data and enters PRE on the next cycle.
- TCK bit slot = 2*CLK_DIV clk_in cycles:
  - Low phase first (CLK_DIV cycles), then high phase (CLK_DIV cycles).
  - TMS/TDI update on the first cycle of the low phase.
  - TDO is sampled on the clk_in edge where jtag_tck goes 0->1.
- TMS sequences (TAP assumed in Run-Test/Idle between commands):
  - TAP_RESET:
    - jtag_trstn=0 for the whole command.
    - 5 slots TMS=1, then 1 slot TMS=0, for 6 TCKs total.
    - cmd_len is ignored. rsp_data=0.
  - SCAN_DR:
    - PRE: TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR).
    - SHIFT: len slots, TDI=data[i], TMS=0 except TMS=1 on the last bit (Exit1).
    - POST: TMS 1,0 (Update, Idle).
    - Total TCKs = len+5.
  - SCAN_IR: PRE TMS 1,1,0,0, then the same as SCAN_DR. Total TCKs = len+6.
  - IDLE_CLK: len slots with TMS=0, TDI=0. rsp_data=0.
- Illegal length:
  - Applies to SCAN_* with len=0 or len>DATA_W.
  - No TCK edges are produced. Go directly to RSP with rsp_err=1, rsp_data=0.
  - IDLE_CLK with len=0 also produces no TCK edges. It responds with rsp_err=0 and is not illegal.
  - IDLE_CLK with len>DATA_W is legal; the counter uses LEN_W bits.
- Capture: a shift register fills at bit index = shift counter. Unshifted bits stay 0.
- RSP:
  - rsp_valid is held, with stable data, until rsp_ready. Then the FSM returns to IDLE and cmd_ready=1 on the following cycle.
  - jtag_tck stays 0 and jtag_tms=0 while waiting.
  - Back-to-back commands insert no extra TCK slots.
- At the end of every command jtag_tck=0, TAP in Run-Test/Idle, jtag_trstn=1.
- busy = !(FSM==IDLE).

Test Plan:
- Reset then idle 20 cycles -> all outputs at their reset values; no jtag_tck edges; cmd_ready=1.
- TAP_RESET, CLK_DIV=4:
  - exactly 6 rising TCKs; TMS pattern 1,1,1,1,1,0; jtag_trstn low throughout.
  - rsp_valid asserts with rsp_data=0, rsp_err=0.
  - Cycles from accept to rsp_valid match 6*8 plus the FSM overhead documented in RTL.
- Bench TAP model (IR=5 bits, IDCODE=0x249511C3):
  - SCAN_IR len=5 data=5'h01, then SCAN_DR len=32 data=0.
  - Required: rsp_data=0x249511C3, upper 32 bits zero.
  - Rising TCK counts: 11 for the IR scan, 37 for the DR scan.
  - TAP model ends in Run-Test/Idle.
- Bypass loopback: SCAN_DR len=8 data=8'hA5 with the TAP in BYPASS -> rsp_data=8'h4A (one-bit delay, first bit 0).
- SCAN_DR len=0, then len=DATA_W+1 -> rsp_err=1 for each, no TCK activity; IDLE_CLK len=0 -> rsp_err=0, no TCK.
- Hold rsp_ready=0 for 50 cycles -> rsp_valid/rsp_data stable, jtag_tck=0, cmd_ready=0.
- Assert reset in the middle of a 32-bit DR shift -> next cycle outputs equal their reset values; a following IDCODE scan after TAP_RESET returns 0x249511C3.

Source files
------------

// File: rtl/jtag_master_seq.sv
// jtag_master_seq: on-chip IEEE 1149.1 JTAG master driven by a command stream.
//
// Runs one command at a time: TAP reset, IR scan, DR scan or free-running idle
// clocks. For each command it produces TCK/TMS/TDI/TRSTn, captures TDO, and
// returns one response. The TAP is assumed to be in Run-Test/Idle between
// commands, and every command leaves it there.
//
// Ports
//   clk_in, reset         system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only when idle
//   cmd_op                0=TAP_RESET 1=SCAN_IR 2=SCAN_DR 3=IDLE_CLK
//   cmd_len               scan length in bits, or TCK count for IDLE_CLK
//   cmd_data              TDI bits, LSB shifted first
//   rsp_valid/rsp_ready   response handshake; data is held until consumed
//   rsp_data              captured TDO bits (bit i = i-th captured bit)
//   rsp_err               scan command rejected for an illegal length
//   busy                  high from command accept until response handshake
//   jtag_tck/tms/tdi      TAP drive
//   jtag_trstn            TAP reset, active low, held for TAP_RESET commands
//   jtag_tdo              TAP data out
//
// Timing: a TCK slot is 2*CLK_DIV clk_in cycles, low half first. TMS/TDI
// change on the edge that starts a slot; TDO is sampled on the edge that
// raises TCK. The first slot starts on the accept edge, so rsp_valid rises
// exactly 2*CLK_DIV*(TCK count) clk_in cycles after the accept edge; commands
// that produce no TCKs respond on the accept edge itself. There is no further
// FSM overhead.

module jtag_master_seq #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LEN_W   = $clog2(DATA_W + 1),
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              jtag_tck,
  output logic              jtag_tms,
  output logic              jtag_tdi,
  output logic              jtag_trstn,
  input  logic              jtag_tdo
);

  typedef enum logic [1:0] {
    OpTapReset = 2'd0,
    OpScanIr   = 2'd1,
    OpScanDr   = 2'd2,
    OpIdleClk  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StShift,
    StPost,
    StRsp
  } state_e;

  // The slot counter must also hold the 6-slot TAP reset sequence.
  localparam int unsigned CNT_W = (LEN_W > 3) ? LEN_W : 3;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DivRise = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LenMax  = LEN_W'(DATA_W);

  state_e              r_state;
  op_e                 r_op;
  logic [LEN_W-1:0]    r_len;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_cnt;
  logic [DIV_W-1:0]    r_div;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;
  logic                r_tck;
  logic                r_tms;
  logic                r_tdi;
  logic                r_trstn;

  op_e                 w_cmd_op;
  logic                w_len_zero;
  logic                w_len_big;
  logic                w_cmd_no_tck;
  logic                w_cmd_err;
  logic [CNT_W-1:0]    w_len_ext;
  logic [CNT_W-1:0]    w_phase_len;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_phase_done;
  state_e              w_nx_state;
  logic [CNT_W-1:0]    w_nx_cnt;
  logic                w_nx_tms;
  logic                w_nx_tdi;
  logic                w_capture;

  // Command legality, evaluated on the raw command inputs at accept time.
  assign w_cmd_op   = op_e'(cmd_op);
  assign w_len_zero = (cmd_len == '0);
  assign w_len_big  = (cmd_len > LenMax);

  always_comb begin
    w_cmd_err    = 1'b0;
    w_cmd_no_tck = 1'b0;
    case (w_cmd_op)
      OpScanIr, OpScanDr: begin
        w_cmd_err    = w_len_zero | w_len_big;
        w_cmd_no_tck = w_len_zero | w_len_big;
      end
      // Zero idle clocks is a legal no-op, not an error.
      OpIdleClk: w_cmd_no_tck = w_len_zero;
      default: ;
    endcase
  end

  // Number of slots in the current phase.
  assign w_len_ext = CNT_W'(r_len);

  always_comb begin
    w_phase_len = CNT_W'(2);
    case (r_state)
      StPre: begin
        if (r_op == OpTapReset) begin
          w_phase_len = CNT_W'(6);
        end else if (r_op == OpScanIr) begin
          w_phase_len = CNT_W'(4);
        end else begin
          w_phase_len = CNT_W'(3);
        end
      end
      StShift: w_phase_len = w_len_ext;
      default: w_phase_len = CNT_W'(2);
    endcase
  end

  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_phase_done = (w_cnt_inc >= w_phase_len);

  // Which slot comes next when the current one ends.
  always_comb begin
    w_nx_state = r_state;
    w_nx_cnt   = w_cnt_inc;
    if (w_phase_done) begin
      w_nx_cnt = '0;
      case (r_state)
        StPre:   w_nx_state = (r_op == OpTapReset) ? StRsp : StShift;
        StShift: w_nx_state = (r_op == OpIdleClk) ? StRsp : StPost;
        default: w_nx_state = StRsp;
      endcase
    end
  end

  // TMS/TDI for the next slot.
  always_comb begin
    w_nx_tms = 1'b0;
    w_nx_tdi = 1'b0;
    case (w_nx_state)
      StPre: begin
        case (r_op)
          OpTapReset: w_nx_tms = (w_nx_cnt < CNT_W'(5));  // 1,1,1,1,1,0
          OpScanIr:   w_nx_tms = (w_nx_cnt < CNT_W'(2));  // 1,1,0,0
          default:    w_nx_tms = (w_nx_cnt == '0);        // 1,0,0
        endcase
      end
      StShift: begin
        if (r_op != OpIdleClk) begin
          // Leave Shift on the last bit so the TAP lands in Exit1.
          w_nx_tms = (w_nx_cnt == (w_len_ext - CNT_W'(1)));
          w_nx_tdi = |(r_data & (DATA_W'(1) << w_nx_cnt));
        end
      end
      StPost:  w_nx_tms = (w_nx_cnt == '0);               // 1,0
      default: ;
    endcase
  end

  assign w_capture = (r_state == StShift) && (r_op != OpIdleClk);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state     <= StIdle;
      r_op        <= OpTapReset;
      r_len       <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_div       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_trstn     <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (cmd_valid) begin
            r_op       <= w_cmd_op;
            r_len      <= cmd_len;
            r_data     <= cmd_data;
            r_cnt      <= '0;
            r_div      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_tdi      <= 1'b0;
            if (w_cmd_no_tck) begin
              r_state     <= StRsp;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_cmd_err;
              r_tms       <= 1'b0;
            end else begin
              // The accept edge starts the first slot; its TMS is 1 for
              // everything except idle clocks.
              r_state <= (w_cmd_op == OpIdleClk) ? StShift : StPre;
              r_tms   <= (w_cmd_op != OpIdleClk);
              r_trstn <= (w_cmd_op != OpTapReset);
            end
          end
        end

        StPre, StShift, StPost: begin
          if (r_div == DivRise) begin
            r_tck <= 1'b1;
            r_div <= r_div + DIV_W'(1);
            // TDO still holds the value the TAP drove on the last falling TCK.
            if (w_capture) begin
              r_rsp_data <= r_rsp_data | (DATA_W'(jtag_tdo) << r_cnt);
            end
          end else if (r_div == DivLast) begin
            r_tck   <= 1'b0;
            r_div   <= '0;
            r_cnt   <= w_nx_cnt;
            r_state <= w_nx_state;
            r_tms   <= w_nx_tms;
            r_tdi   <= w_nx_tdi;
            if (w_nx_state == StRsp) begin
              r_rsp_valid <= 1'b1;
              r_trstn     <= 1'b1;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        StRsp: begin
          if (rsp_ready) begin
            r_state     <= StIdle;
            r_rsp_valid <= 1'b0;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = (r_state == StIdle);
  assign busy       = (r_state != StIdle);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign jtag_tck   = r_tck;
  assign jtag_tms   = r_tms;
  assign jtag_tdi   = r_tdi;
  assign jtag_trstn = r_trstn;

endmodule
